// File: rtl/l1c_arb_pkg.sv
// Shared types and constants for the L1 cache memory-port arbiter.
// Size encodings are shared with the L1 caches.
package l1c_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10,
        GAP     = 2'b11
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    localparam logic [2:0] CACHE_BYTE  = 3'b000;
    localparam logic [2:0] CACHE_HWORD = 3'b001;
    localparam logic [2:0] CACHE_WORD  = 3'b010;

    // Writes and uncached stores are always single beat.
    function automatic logic [1:0] eff_len(input logic write, input logic [1:0] len);
        return write ? 2'b00 : len;
    endfunction

endpackage

// File: rtl/l1c_arb_pick.sv
// Combinational winner selection between the I and D requesters.
// On a tie, the side that did not own the port last wins.
module l1c_arb_pick
    import l1c_arb_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  logic [1:0] last_owner,
    output logic       grant_i,
    output logic       grant_d
);

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && d_req) begin
            if (last_owner == OWN_D) begin
                grant_i = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else begin
            grant_i = i_req;
            grant_d = d_req;
        end
    end

endmodule

// File: rtl/l1c_mem_arbiter.sv
// Shares one external memory port between the I and D L1 caches, holding the grant for a whole burst.
// Optional round-robin tie-break enabled by defining ARB_RR_EN (default: D wins ties).
module l1c_mem_arbiter
    import l1c_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I_req,
    input  logic [ADDR_W-1:0] I_addr,
    input  logic              I_write,
    input  logic [DATA_W-1:0] I_in,
    input  logic [2:0]        I_type,
    input  logic [1:0]        I_len,
    output logic [DATA_W-1:0] I_out,
    output logic              I_wait,
    input  logic              D_req,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic              D_write,
    input  logic [DATA_W-1:0] D_in,
    input  logic [2:0]        D_type,
    input  logic [1:0]        D_len,
    output logic [DATA_W-1:0] D_out,
    output logic              D_wait,
    output logic              M_req,
    output logic [ADDR_W-1:0] M_addr,
    output logic              M_write,
    output logic [DATA_W-1:0] M_in,
    output logic [2:0]        M_type,
    output logic [1:0]        M_len,
    input  logic [DATA_W-1:0] M_out,
    input  logic              M_wait,
    output logic [1:0]        owner
);

    arb_state_t        state_reg, state_next;
    logic [1:0]        beat_cnt_reg, beat_cnt_next;
    logic [ADDR_W-1:0] hold_addr_reg;
    logic              hold_write_reg;
    logic [DATA_W-1:0] hold_in_reg;
    logic [2:0]        hold_type_reg;
    logic [1:0]        hold_len_reg;

    logic       grant_i, grant_d;
    logic       latch;
    logic [1:0] last_owner;

    l1c_arb_pick u_pick (
        .i_req      (I_req),
        .d_req      (D_req),
        .last_owner (last_owner),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

`ifdef ARB_RR_EN
    logic [1:0] last_owner_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_reg <= OWN_I;
        end else if (state_reg == IDLE && grant_d) begin
            last_owner_reg <= OWN_D;
        end else if (state_reg == IDLE && grant_i) begin
            last_owner_reg <= OWN_I;
        end
    end

    assign last_owner = last_owner_reg;
`else
    // Tying last owner to I makes every tie resolve to D.
    assign last_owner = OWN_I;
`endif

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        latch         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_i || grant_d) begin
                    latch         = 1'b1;
                    beat_cnt_next = 2'd0;
                    state_next    = grant_d ? GRANT_D : GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (!M_wait) begin
                    if (beat_cnt_reg == hold_len_reg) begin
                        state_next = GAP;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 2'd1;
                    end
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            beat_cnt_reg   <= 2'd0;
            hold_addr_reg  <= '0;
            hold_write_reg <= 1'b0;
            hold_in_reg    <= '0;
            hold_type_reg  <= 3'd0;
            hold_len_reg   <= 2'd0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            if (latch) begin
                hold_addr_reg  <= grant_d ? D_addr  : I_addr;
                hold_write_reg <= grant_d ? D_write : I_write;
                hold_in_reg    <= grant_d ? D_in    : I_in;
                hold_type_reg  <= grant_d ? D_type  : I_type;
                hold_len_reg   <= grant_d ? eff_len(D_write, D_len) : eff_len(I_write, I_len);
            end
        end
    end

    always_comb begin
        M_req   = (state_reg == GRANT_I) || (state_reg == GRANT_D);
        M_addr  = hold_addr_reg;
        M_write = hold_write_reg;
        M_in    = hold_in_reg;
        M_type  = hold_type_reg;
        M_len   = hold_len_reg;
        owner   = OWN_NONE;
        I_wait  = 1'b1;
        I_out   = '0;
        D_wait  = 1'b1;
        D_out   = '0;
        if (state_reg == GRANT_I) begin
            owner  = OWN_I;
            I_wait = M_wait;
            I_out  = M_out;
        end else if (state_reg == GRANT_D) begin
            owner  = OWN_D;
            D_wait = M_wait;
            D_out  = M_out;
        end
    end

endmodule
